bus_rr_arbiter: RTL
===================

BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

Interface
REQ-001 The block SHALL take parameter NUM_MASTERS, default 2, number of requesting masters (range 2..16).
REQ-002 The block SHALL take parameter CLK_MAX_TIMEOUT, default 10, max clk cycles to wait for slave address_valid (range 1..255).
REQ-003 Port clk  in  1  the single clock; all state on posedge clk.
REQ-004 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port barq_i  in  NUM_MASTERS  bus request per master; level, held for the whole transaction.
REQ-006 Port bagd_o  out  NUM_MASTERS  bus grant, one-hot or zero.
REQ-007 Port address_valid_i  in  1  OR of slave address decodes; level.
REQ-008 Port target_ready_o  out  1  address phase open; slaves may decode addr_bus.
REQ-009 Port data_strobe_o  out  1  single-cycle data transfer strobe.
REQ-010 Port error_o  out  1  timeout error; high while in ERROR.
REQ-011 Port owner_o  out  $clog2(NUM_MASTERS)  index of the current or last granted master.

Function
REQ-012 All outputs SHALL be registered (no combinational input-to-output path).
REQ-013 The FSM SHALL have states IDLE, ADDR, STROBE, HOLD and ERROR.
REQ-014 IDLE: bagd_o=0, target_ready_o=0; if any barq_i bit is set, the block SHALL grant the first requester in round-robin order starting at owner_o+1 (mod NUM_MASTERS) and go to ADDR; bagd_o and owner_o update on that edge (grant latency 1 cycle).
REQ-015 Simultaneous requests SHALL resolve by round-robin only; a master granted last SHALL have lowest priority next.
REQ-016 ADDR: target_ready_o=1, bagd_o held; timeout counter SHALL start at 0 on entry and increment each cycle.
REQ-017 In ADDR, address_valid_i=1 SHALL take priority over timeout and move the FSM to STROBE.
REQ-018 In ADDR, counter reaching CLK_MAX_TIMEOUT with address_valid_i=0 SHALL move the FSM to ERROR.
REQ-019 In ADDR, barq_i[owner]=0 (master abort) SHALL move the FSM to IDLE with no strobe and no error; abort has priority over valid and timeout.
REQ-020 STROBE: data_strobe_o=1 and target_ready_o=1 for exactly one cycle, then the FSM SHALL go to HOLD.
REQ-021 HOLD: target_ready_o=0, bagd_o held; on barq_i[owner]=0 the FSM SHALL go to IDLE, clearing bagd_o on that edge.
REQ-022 ERROR: bagd_o=0, target_ready_o=0, error_o=1; the FSM SHALL stay in ERROR until barq_i[owner]=0, then go to IDLE.
REQ-023 Requests from non-owner masters SHALL be ignored outside IDLE; there is no preemption.
REQ-024 Counter width SHALL be $clog2(CLK_MAX_TIMEOUT+1); it SHALL saturate and never wrap.
REQ-025 owner_o round-robin pointer SHALL wrap from NUM_MASTERS-1 to 0.

Reset
REQ-026 On rst_n=0 the block SHALL asynchronously enter IDLE with bagd_o=0, target_ready_o=0, data_strobe_o=0, error_o=0, counter=0 and owner_o=NUM_MASTERS-1, so master 0 wins first.
REQ-027 Reset asserted mid-transaction (any state) SHALL drop all outputs immediately, with no strobe after release.
REQ-028 The first grant SHALL occur no earlier than the second posedge after rst_n deasserts.

Structure
REQ-029 A shared package bus_pkg SHALL hold the FSM state enum bus_arb_state_t and a default timeout constant BUS_TIMEOUT_DEFAULT=10.
REQ-030 The round-robin selector SHALL be one combinational sub-module, rr_pick (inputs: req vector and last index; outputs: found and next index); the FSM and counter stay in bus_rr_arbiter.

Verification
REQ-031 Single request: barq_i=01 -> bagd_o=01 after 1 cycle; slave asserts valid 3 cycles into ADDR -> one data_strobe_o pulse; barq_i=00 -> bagd_o=00 next edge.
REQ-032 Contention: barq_i=11 held, masters release after their strobe and re-request -> grant order 0,1,0,1, each with exactly one strobe.
REQ-033 Timeout: CLK_MAX_TIMEOUT=10, address_valid_i never set -> error_o rises 10 cycles after ADDR entry, bagd_o=0, data_strobe_o never set; barq_i low -> IDLE, error_o=0.
REQ-034 Boundary: valid asserted in the same cycle the counter hits 10 -> STROBE, no error.
REQ-035 Abort: master drops barq_i in cycle 2 of ADDR -> IDLE, no strobe, no error; the other pending master is granted next cycle.
REQ-036 Reset in STROBE/HOLD: rst_n=0 -> all outputs 0 asynchronously; after release barq_i=10 -> bagd_o=10 (reset pointer 1, next pick scans 0 then 1).

Source files
------------

// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_pkg
// Brief    : Shared FSM state type and default timeout for the bus arbiter.
// Revision : 1.0
// ============================================================================
package bus_pkg;

  localparam int BUS_TIMEOUT_DEFAULT = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_ERROR  = 3'd4
  } bus_arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin selector; scans from i_last+1 upward.
// Revision : 1.0
// ============================================================================
module rr_pick #(
  parameter int NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0]         i_req,
  input  logic [$clog2(NUM_MASTERS)-1:0] i_last,
  output logic                           o_found,
  output logic [$clog2(NUM_MASTERS)-1:0] o_next
);

  localparam int C_IDX_W = $clog2(NUM_MASTERS);

  // Walk from lowest to highest priority so the nearest requester after
  // i_last is the one left standing.
  always_comb begin
    logic [C_IDX_W-1:0] v_idx;
    v_idx   = '0;
    o_found = 1'b0;
    o_next  = i_last;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      v_idx = C_IDX_W'((int'(i_last) + k) % NUM_MASTERS);
      if (i_req[v_idx]) begin
        o_found = 1'b1;
        o_next  = v_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_rr_arbiter
// Brief    : Round-robin bus arbiter with address-phase timeout and abort.
// Revision : 1.0
// ============================================================================
module bus_rr_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS     = 2,
  parameter int CLK_MAX_TIMEOUT = BUS_TIMEOUT_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_MASTERS-1:0]         barq_i,
  output logic [NUM_MASTERS-1:0]         bagd_o,
  input  logic                           address_valid_i,
  output logic                           target_ready_o,
  output logic                           data_strobe_o,
  output logic                           error_o,
  output logic [$clog2(NUM_MASTERS)-1:0] owner_o
);

  localparam int                C_IDX_W   = $clog2(NUM_MASTERS);
  localparam int                C_CNT_W   = $clog2(CLK_MAX_TIMEOUT + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(CLK_MAX_TIMEOUT);

  bus_arb_state_t               r_state;
  bus_arb_state_t               w_state_nxt;
  logic [C_CNT_W-1:0]           r_cnt;
  logic [C_CNT_W-1:0]           w_cnt_nxt;
  logic [C_CNT_W-1:0]           w_cnt_inc;
  logic [C_IDX_W-1:0]           r_owner;
  logic [C_IDX_W-1:0]           w_owner_nxt;
  logic [NUM_MASTERS-1:0]       r_grant;
  logic                         r_tready;
  logic                         r_strobe;
  logic                         r_error;
  logic                         r_armed;
  logic                         w_found;
  logic [C_IDX_W-1:0]           w_pick;
  logic                         w_owner_req;

  rr_pick #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_rr_pick (
    .i_req   (barq_i),
    .i_last  (r_owner),
    .o_found (w_found),
    .o_next  (w_pick)
  );

  assign w_owner_req = barq_i[r_owner];
  assign w_cnt_inc   = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + C_CNT_W'(1);

  // Abort beats valid, valid beats timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (r_armed && w_found) begin
          w_state_nxt = ST_ADDR;
          w_owner_nxt = w_pick;
          w_cnt_nxt   = '0;
        end
      end
      ST_ADDR: begin
        w_cnt_nxt = w_cnt_inc;
        if (!w_owner_req) begin
          w_state_nxt = ST_IDLE;
        end else if (address_valid_i) begin
          w_state_nxt = ST_STROBE;
        end else if (w_cnt_inc == C_CNT_MAX) begin
          w_state_nxt = ST_ERROR;
        end
      end
      ST_STROBE: w_state_nxt = ST_HOLD;
      ST_HOLD:   if (!w_owner_req) w_state_nxt = ST_IDLE;
      ST_ERROR:  if (!w_owner_req) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave flops directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_owner  <= C_IDX_W'(NUM_MASTERS - 1);
      r_grant  <= '0;
      r_tready <= 1'b0;
      r_strobe <= 1'b0;
      r_error  <= 1'b0;
      r_armed  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_owner  <= w_owner_nxt;
      r_armed  <= 1'b1;
      r_grant  <= (w_state_nxt == ST_ADDR || w_state_nxt == ST_STROBE ||
                   w_state_nxt == ST_HOLD) ? (NUM_MASTERS'(1) << w_owner_nxt) : '0;
      r_tready <= (w_state_nxt == ST_ADDR || w_state_nxt == ST_STROBE);
      r_strobe <= (w_state_nxt == ST_STROBE);
      r_error  <= (w_state_nxt == ST_ERROR);
    end
  end

  assign bagd_o         = r_grant;
  assign target_ready_o = r_tready;
  assign data_strobe_o  = r_strobe;
  assign error_o        = r_error;
  assign owner_o        = r_owner;

endmodule
`default_nettype wire
